mips_cpu_regfile_mp: RTL and testbench

//  Next-generation general-purpose register file for the MIPS32 core.
//  - Parametrised width, depth and number of read ports.
//  - Two write ports:
//    - W0: ALU/writeback.
//    - W1: load/multicycle return.
//  - Optional same-cycle write-to-read bypass.
//  - Per-register busy scoreboard, so issue can stall on outstanding loads.
//  - Sits between decode (read), writeback (write) and the load unit (reserve/return).

---
 rtl/mips_cpu_pkg.sv | 9 +
 rtl/mips_cpu_regfile_scoreboard.sv | 32 +++
 rtl/mips_cpu_regfile_mp.sv | 94 +++++++++
 tb/tb_mips_cpu_regfile_mp.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS32 core constants and basic register-file types.
package mips_cpu_pkg;
  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_RA   = 31;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/mips_cpu_regfile_scoreboard.sv
// Per-register busy bits: set when a load is reserved, cleared by its wr1 return.
module mips_cpu_regfile_scoreboard
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 any_busy
);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [2**ADDR_W-1:0] r_busy;

  // Set is applied after clear so a same-cycle reserve keeps the new load outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (clr_en) r_busy[clr_addr] <= 1'b0;
      if (rsv_en && rsv_addr != ZERO_A) r_busy[rsv_addr] <= 1'b1;
    end
  end

  assign busy     = r_busy;
  assign any_busy = |r_busy;
endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-read, dual-write GPR file with optional write bypass and load busy tracking.
module mips_cpu_regfile_mp
  import mips_cpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int PROBE_REG = REG_V0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [DATA_W-1:0]        register_probe,
  output logic                     any_busy
);
  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] PROBE_A = ADDR_W'(PROBE_REG);

  if (PROBE_REG >= DEPTH || PROBE_REG < 0) begin : g_bad_probe
    $error("mips_cpu_regfile_mp: PROBE_REG %0d outside register file", PROBE_REG);
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("mips_cpu_regfile_mp: NUM_RD %0d outside 1..4", NUM_RD);
  end

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_any_busy;

  // wr1 is issued second so it wins an address collision with wr0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (wr0_en && wr0_addr != ZERO_A) r_regs[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != ZERO_A) r_regs[wr1_addr] <= wr1_data;
    end
  end

  mips_cpu_regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_en   (wr1_en),
    .clr_addr (wr1_addr),
    .busy     (w_busy),
    .any_busy (w_any_busy)
  );

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a, input logic byp);
    logic [DATA_W-1:0] v;
    v = r_regs[a];
    if (a == ZERO_A)                        v = '0;
    else if (byp && wr1_en && wr1_addr == a) v = wr1_data;
    else if (byp && wr0_en && wr0_addr == a) v = wr0_data;
    return v;
  endfunction

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = '0;
      rd_busy[k]                  = 1'b0;
      if (!reset) begin
        rd_data[k*DATA_W +: DATA_W] = f_read(w_addr, BYPASS != 0);
        rd_busy[k]                  = w_busy[w_addr];
      end
    end
  end

  // The probe is a debug view of architectural state as it is being written.
  always_comb begin
    register_probe = '0;
    any_busy       = 1'b0;
    if (!reset) begin
      register_probe = f_read(PROBE_A, 1'b1);
      any_busy       = w_any_busy;
    end
  end
endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Random and directed register-file stimulus, scoreboard-checked against a behavioural model.
module tb_mips_cpu_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr0_en, wr1_en, rsv_en;
  logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] probe_b, probe_n;
  logic        any_b, any_n;

  always #5 clk = ~clk;

  mips_cpu_regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b), .register_probe(probe_b), .any_busy(any_b));

  mips_cpu_regfile_mp #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_n), .rd_busy(rd_busy_n), .register_probe(probe_n), .any_busy(any_n));

  typedef struct {
    logic [31:0] byp [2];
    logic [31:0] nob [2];
    logic        busy [2];
    logic [31:0] probe;
    logic        any;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem  [32];
  bit          busy [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value of register a as seen in the current cycle, by the architectural rules.
  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return mem[a];
  endfunction

  task automatic step(input bit rst, input bit w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                      input bit w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                      input bit re, input logic [4:0] ra, input logic [4:0] a0, input logic [4:0] a1);
    exp_t       e;
    logic [4:0] ad [2];
    @(posedge clk); #1;
    reset = rst; wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d; rsv_en = re; rsv_addr = ra;
    rd_addr = {a1, a0};
    ad[0] = a0; ad[1] = a1;
    e.any = 1'b0;
    for (int i = 0; i < 32; i++) if (busy[i]) e.any = 1'b1;
    for (int k = 0; k < 2; k++) begin
      e.byp[k]  = rst ? 32'h0 : mread(ad[k], 1);
      e.nob[k]  = rst ? 32'h0 : mread(ad[k], 0);
      e.busy[k] = rst ? 1'b0 : busy[ad[k]];
    end
    e.probe = rst ? 32'h0 : mread(5'd2, 1);
    if (rst) e.any = 1'b0;
    q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; busy[i] = 0; end
    end else begin
      if (w0e && w0a != 0) mem[w0a] = w0d;
      if (w1e && w1a != 0) mem[w1a] = w1d;
      if (w1e) busy[w1a] = 0;
      if (re && ra != 0) busy[ra] = 1;
    end
  endtask

  // Monitor: outputs are combinational, so each driven cycle is sampled at its falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd0_byp",  rd_data_b[31:0],  e.byp[0]);
        chk("rd1_byp",  rd_data_b[63:32], e.byp[1]);
        chk("rd0_nob",  rd_data_n[31:0],  e.nob[0]);
        chk("rd1_nob",  rd_data_n[63:32], e.nob[1]);
        chk("busy0",    {31'h0, rd_busy_b[0]}, {31'h0, e.busy[0]});
        chk("busy1",    {31'h0, rd_busy_b[1]}, {31'h0, e.busy[1]});
        chk("busy_nob", {30'h0, rd_busy_n}, {30'h0, e.busy[1], e.busy[0]});
        chk("probe",    probe_b, e.probe);
        chk("probe_nob", probe_n, e.probe);
        chk("any_busy", {30'h0, any_n, any_b}, {30'h0, e.any, e.any});
      end
    end
  end

  initial begin
    logic [4:0] a [5];
    for (int i = 0; i < 32; i++) begin mem[i] = 32'hx; busy[i] = 0; end
    reset = 1'b1; wr0_en = 0; wr1_en = 0; rsv_en = 0;
    wr0_addr = 0; wr1_addr = 0; rsv_addr = 0; wr0_data = 0; wr1_data = 0; rd_addr = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 32'h1234, 0, 0, 0, 1, 4, 3, 4);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
    // write then read, same-cycle bypass vs stored value
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    // wr0/wr1 collision
    step(0, 1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0, 7, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    // register 0 is immutable and never busy
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // busy scoreboard on r9
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 1, 9, 32'h77, 0, 0, 0, 0, 0, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 1, 9, 32'h42, 0, 0, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 1, 9, 32'h43, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 2);
    // probe register write, then reset mid-operation dropping a wr0
    step(0, 1, 2, 32'h5, 0, 0, 0, 0, 0, 2, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 9);
    step(1, 1, 3, 32'hABCD, 0, 0, 0, 1, 6, 2, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 9);

    for (int n = 0; n < 1500; n++) begin
      for (int j = 0; j < 5; j++)
        a[j] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 1) == 1, a[0], $urandom,
           $urandom_range(0, 2) == 0, a[1], $urandom,
           $urandom_range(0, 3) == 0, a[2], a[3], a[4]);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
